// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP decode,
// byte receive/transmit with open-drain SDA and no clock stretching.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       rd_mode,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_p;
  logic                   sda_p;
  logic                   sda_oe;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   byte_done;
  logic                   ack_in;

  logic scl_s, sda_s;
  logic start_det, stop_det, scl_rise, scl_fall;

  // Reset releases the line combinationally, not one clock later
  assign i2c_sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign start_det = scl_p & scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_p & scl_s & ~sda_p & sda_s;
  assign scl_rise  = ~scl_p & scl_s;
  assign scl_fall  = scl_p & ~scl_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      bit_cnt   <= 3'd7;
      shift     <= 8'h00;
      byte_done <= 1'b0;
      ack_in    <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rd_mode   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        rd_mode <= 1'b0;
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise && !byte_done) begin
              shift <= {shift[6:0], sda_s};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else bit_cnt <= bit_cnt - 3'd1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (shift[7:1] == SLAVE_ADDR) begin
                sda_oe  <= 1'b1;
                state   <= ADDR_ACK;
                busy    <= 1'b1;
                rd_mode <= shift[0];
              end else begin
                sda_oe  <= 1'b0;
                state   <= WAIT_STOP;
                busy    <= 1'b0;
                rd_mode <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd7;
              if (rd_mode) begin
                shift  <= tx_data;
                tx_req <= 1'b1;
                sda_oe <= ~tx_data[7];
                state  <= TX;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX;
              end
            end
          end
          RX: begin
            if (scl_rise && !byte_done) begin
              shift <= {shift[6:0], sda_s};
              if (bit_cnt == 3'd0) begin
                rx_data   <= {shift[6:0], sda_s};
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= RX;
            end
          end
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
                sda_oe  <= ~shift[6];
                shift   <= {shift[6:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              ack_in <= sda_s;
            end else if (scl_fall) begin
              if (!ack_in) begin
                shift   <= tx_data;
                tx_req  <= 1'b1;
                sda_oe  <= ~tx_data[7];
                bit_cnt <= 3'd7;
                state   <= TX;
              end else begin
                sda_oe  <= 1'b0;
                state   <= WAIT_STOP;
                rd_mode <= 1'b0;
                busy    <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Scoreboard bench for i2c_slave: a bus-level I2C master drives
// directed and random transfers; a negedge monitor checks outputs.
module tb_i2c_slave;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rd_mode, busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = sda_m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl_m),
    .i2c_sda  (sda_bus),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .rd_mode  (rd_mode),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  bit no_drive = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_obs[$];
  logic       exp_ack[$];
  logic       ack_obs[$];
  logic [7:0] tx_src[$];
  logic [7:0] pl[$];
  string      pend_nm[$];
  logic [7:0] pend_got[$];
  logic [7:0] pend_exp[$];

  // monitor: every comparison is made here
  always @(negedge clk) begin
    logic [7:0] g, e;
    logic ga, ea;
    string nm;
    if (rx_valid) begin
      checks++;
      if (exp_rx.size() == 0) begin
        errors++;
        $display("FAIL rx_extra got %h exp none", rx_data);
      end else begin
        e = exp_rx.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data got %h exp %h", rx_data, e);
        end
      end
    end
    if (tx_req) begin
      checks++;
      if (tx_src.size() == 0) begin
        errors++;
        $display("FAIL tx_req_extra got 1 exp 0");
      end else begin
        void'(tx_src.pop_front());
      end
    end
    tx_data = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
    if (ack_obs.size() != 0) begin
      ga = ack_obs.pop_front();
      checks++;
      if (exp_ack.size() == 0) begin
        errors++;
        $display("FAIL ack_extra got %b exp none", ga);
      end else begin
        ea = exp_ack.pop_front();
        if (ga !== ea) begin
          errors++;
          $display("FAIL ack got %b exp %b", ga, ea);
        end
      end
    end
    if (rd_obs.size() != 0) begin
      g = rd_obs.pop_front();
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_extra got %h exp none", g);
      end else begin
        e = exp_rd.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL rd_byte got %h exp %h", g, e);
        end
      end
    end
    if (pend_nm.size() != 0) begin
      nm = pend_nm.pop_front();
      g  = pend_got.pop_front();
      e  = pend_exp.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got %h exp %h", nm, g, e);
      end
    end
    if (no_drive && !sda_m_oe && sda_bus === 1'b0) low_cnt++;
  end

  task automatic chk(input string nm, input logic [7:0] g,
                     input logic [7:0] e);
    pend_nm.push_back(nm);
    pend_got.push_back(g);
    pend_exp.push_back(e);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sda(input bit b);
    sda_m_oe = !b;
  endtask

  task automatic start_cond();
    set_sda(1'b1);
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    set_sda(1'b0);
    wclk(Q);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    wclk(Q);
    set_sda(1'b0);
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    set_sda(1'b1);
    wclk(2 * Q);
  endtask

  // simul: SDA changes in the same instant SCL falls
  task automatic wr_byte(input logic [7:0] b, input bit simul,
                         output logic ack);
    logic [7:0] sh;
    sh = b;
    if (simul) set_sda(sh[7]);
    for (int i = 7; i >= 0; i--) begin
      wclk(Q);
      if (!simul) set_sda(sh[7]);
      wclk(Q);
      scl_m = 1'b1;
      wclk(2 * Q);
      scl_m = 1'b0;
      sh = {sh[6:0], 1'b0};
      if (simul) set_sda(i == 0 ? 1'b1 : sh[7]);
    end
    set_sda(1'b1);
    wclk(2 * Q);
    scl_m = 1'b1;
    wclk(Q);
    ack = sda_bus;
    wclk(Q);
    scl_m = 1'b0;
  endtask

  task automatic rd_byte(input bit give_ack, output logic [7:0] b);
    b = 8'h00;
    set_sda(1'b1);
    for (int i = 0; i < 8; i++) begin
      wclk(2 * Q);
      scl_m = 1'b1;
      wclk(Q);
      b = {b[6:0], sda_bus};
      wclk(Q);
      scl_m = 1'b0;
    end
    wclk(Q);
    set_sda(!give_ack);
    wclk(Q);
    scl_m = 1'b1;
    wclk(2 * Q);
    scl_m = 1'b0;
    set_sda(1'b1);
  endtask

  // payload comes from pl; expectations follow the bus rules directly
  task automatic xfer(input logic [6:0] a, input bit rw,
                      input bit simul, input bit rs_end);
    bit hit;
    int n, c0;
    logic ack;
    logic [7:0] d, got;
    hit = (a == 7'h50);
    n = pl.size();
    if (rw && hit) foreach (pl[k]) tx_src.push_back(pl[k]);
    start_cond();
    no_drive = !hit;
    c0 = low_cnt;
    exp_ack.push_back(!hit);
    wr_byte({a, rw}, simul, ack);
    ack_obs.push_back(ack);
    chk("busy_addr", {7'd0, busy}, {7'd0, hit});
    chk("rd_mode_addr", {7'd0, rd_mode}, {7'd0, hit & rw});
    for (int k = 0; k < n; k++) begin
      d = pl[k];
      if (!rw) begin
        if (hit) exp_rx.push_back(d);
        exp_ack.push_back(!hit);
        wr_byte(d, simul, ack);
        ack_obs.push_back(ack);
      end else begin
        exp_rd.push_back(hit ? d : 8'hFF);
        rd_byte(k != n - 1, got);
        rd_obs.push_back(got);
      end
    end
    if (!hit) begin
      wclk(Q);
      chk("no_drive", 8'(low_cnt - c0), 8'd0);
    end
    no_drive = 1'b0;
    pl.delete();
    if (!rs_end) begin
      stop_cond();
      chk("busy_stop", {7'd0, busy}, 8'd0);
      chk("rd_mode_stop", {7'd0, rd_mode}, 8'd0);
    end
  endtask

  initial begin
    logic [6:0] a;
    logic ack;
    wclk(4);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_flags", {3'd0, rx_valid, tx_req, rd_mode, busy, sda_bus},
        8'h01);
    rst = 1'b0;
    wclk(4 * Q);

    pl = '{8'h3C};
    xfer(7'h50, 1'b0, 1'b0, 1'b0);
    chk("t1_rx_hold", rx_data, 8'h3C);

    pl = '{8'h96, 8'h5A};
    xfer(7'h50, 1'b1, 1'b0, 1'b0);

    pl = '{8'h55};
    xfer(7'h58, 1'b0, 1'b0, 1'b0);

    pl = '{8'h11};
    xfer(7'h50, 1'b0, 1'b0, 1'b1);
    pl = '{8'hE7};
    xfer(7'h50, 1'b1, 1'b0, 1'b0);
    chk("t4_rx_hold", rx_data, 8'h11);

    tx_src.push_back(8'hF7);
    start_cond();
    exp_ack.push_back(1'b0);
    wr_byte({7'h50, 1'b1}, 1'b0, ack);
    ack_obs.push_back(ack);
    set_sda(1'b1);
    for (int i = 0; i < 4; i++) begin
      wclk(2 * Q);
      scl_m = 1'b1;
      wclk(2 * Q);
      scl_m = 1'b0;
    end
    wclk(Q);
    chk("t5_bit3_low", {7'd0, sda_bus}, 8'd0);
    rst = 1'b1;
    wclk(1);
    chk("t5_sda_rel", {7'd0, sda_bus}, 8'd1);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_flags", {4'd0, rx_valid, tx_req, rd_mode, busy}, 8'd0);
    scl_m = 1'b1;
    wclk(2);
    rst = 1'b0;
    wclk(4 * Q);
    pl = '{8'hC3};
    xfer(7'h50, 1'b0, 1'b0, 1'b0);

    pl = '{8'hA5, 8'h5A};
    xfer(7'h50, 1'b0, 1'b1, 1'b0);
    pl = '{8'h3E, 8'hC1};
    xfer(7'h50, 1'b1, 1'b1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      a = 7'h50;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom);
        if (a == 7'h50) a = 7'h51;
      end
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        pl.push_back(8'($urandom));
      xfer(a, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
    end
    stop_cond();

    wclk(10);
    chk("rx_left", 8'(exp_rx.size()), 8'd0);
    chk("rd_left", 8'(exp_rd.size()), 8'd0);
    chk("ack_left", 8'(exp_ack.size()), 8'd0);
    chk("tx_left", 8'(tx_src.size()), 8'd0);
    wclk(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
